// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants and the ALU request bundle handed from issue to ALU.
// Widths here are the single source of truth for XLEN and register address size.
package rv32i_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  typedef struct packed {
    logic [XLEN-1:0]    rs1;
    logic [XLEN-1:0]    rs2;
    logic [3:0]         alusel;
    logic [RADDR_W-1:0] rd;
  } alu_req_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I OP/OP-IMM decode: register addresses, operand B mux, ALU select, legality.
// Select bit 3 is instr[30] for OP, and only for right shifts on OP-IMM (addi imm bit 10 is not sub).
module alu_issue_decode
  import rv32i_pkg::*;
(
  input  logic [31:0]        instr,
  input  logic [XLEN-1:0]    rdata1,
  input  logic [XLEN-1:0]    rdata2,
  output logic [RADDR_W-1:0] raddr1,
  output logic [RADDR_W-1:0] raddr2,
  output alu_req_t           req,
  output logic               illegal_n
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       f3_ok;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign raddr1 = instr[19:15];
  assign raddr2 = instr[24:20];
  assign f3_ok  = (funct3 != F3_SLT) && (funct3 != F3_SLTU);

  always_comb begin
    req.rs1    = rdata1;
    req.rs2    = rdata2;
    req.alusel = {instr[30], funct3};
    req.rd     = instr[11:7];
    illegal_n  = 1'b0;
    case (opcode)
      OPC_OP: begin
        illegal_n = f3_ok && ((funct7 == F7_BASE) ||
                              ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR))));
      end
      OPC_OP_IMM: begin
        req.rs2    = {{(XLEN-12){instr[31]}}, instr[31:20]};
        req.alusel = {(funct3 == F3_SR) && instr[30], funct3};
        if (funct3 == F3_SLL)
          illegal_n = (funct7 == F7_BASE);
        else if (funct3 == F3_SR)
          illegal_n = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        else
          illegal_n = f3_ok;
      end
      default: illegal_n = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the ALU through a main+skid output register pair; 1-cycle latency.
// Optional ALU_ISSUE_STATS_EN adds issued/illegal counters.
module alu_issue_stage
  import rv32i_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  output logic [RADDR_W-1:0] rf_raddr1,
  output logic [RADDR_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]    rf_rdata1,
  input  logic [XLEN-1:0]    rf_rdata2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_rs1,
  output logic [XLEN-1:0]    out_rs2,
  output logic [3:0]         out_alusel,
  output logic [RADDR_W-1:0] out_rd,
  output logic               illegal
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]        stat_issued,
  output logic [31:0]        stat_illegal
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t   state, state_nx;
  alu_req_t dec_req, main_q, skid_q;
  logic     dec_legal;
  logic     accept, legal_accept, drain;

  alu_issue_decode u_decode (
    .instr     (in_instr),
    .rdata1    (rf_rdata1),
    .rdata2    (rf_rdata2),
    .raddr1    (rf_raddr1),
    .raddr2    (rf_raddr2),
    .req       (dec_req),
    .illegal_n (dec_legal)
  );

  assign accept       = in_valid && in_ready;
  assign legal_accept = accept && dec_legal;
  assign drain        = out_valid && out_ready;

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (legal_accept) state_nx = ONE;
      ONE:     if (legal_accept && !drain) state_nx = TWO;
               else if (!legal_accept && drain) state_nx = EMPTY;
      TWO:     if (drain) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  // in_ready/out_valid are registered copies of the next state, keeping out_ready off any input path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= (state_nx != EMPTY);
      in_ready  <= (state_nx != TWO);
      illegal   <= accept && !dec_legal;
      case (state)
        EMPTY: if (legal_accept) main_q <= dec_req;
        ONE: begin
          if (legal_accept && drain) main_q <= dec_req;
          else if (legal_accept)     skid_q <= dec_req;
        end
        TWO:     if (drain) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign out_rs1    = main_q.rs1;
  assign out_rs2    = main_q.rs2;
  assign out_alusel = main_q.alusel;
  assign out_rd     = main_q.rd;

`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued  <= '0;
      stat_illegal <= '0;
    end else begin
      if (drain)                 stat_issued  <= stat_issued + 32'd1;
      if (accept && !dec_legal)  stat_illegal <= stat_illegal + 32'd1;
    end
  end
`endif

endmodule
